// File: rtl/bus_arb.sv
// bus_arb: two-master, single-slave bus arbiter.
// m0 (execute, read/write) normally wins. m1 (fetch, read-only) wins once it
// has lost STARVE_LIMIT arbitrations in a row. Each request is checked for
// size/alignment, then lane-shifted onto the slave. Read data is shifted back
// and sign/zero-extended. A slave that never acks is abandoned after TIMEOUT
// BUSY cycles.
module bus_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_un_sign,
  input  logic [3:0]  m0_byte_mask,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req,
  input  logic        m1_un_sign,
  input  logic [3:0]  m1_byte_mask,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata_o,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic        s_req_o,
  output logic        s_rw_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o
);

  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1, DONE} state_t;

  state_t      state_reg;
  logic [2:0]  starve_reg;
  logic [3:0]  tmo_reg;
  logic        owner_reg;      // 0 = m0, 1 = m1
  logic        we_reg;
  logic        un_reg;
  logic        pend_err_reg;   // request rejected, error response still owed
  logic [3:0]  mask_reg;
  logic [1:0]  off_reg;

  logic        m0_gnt_reg, m0_rvalid_reg, m0_err_reg;
  logic        m1_gnt_reg, m1_rvalid_reg, m1_err_reg;
  logic [31:0] m0_rdata_reg, m1_rdata_reg;
  logic        s_req_reg, s_rw_reg;
  logic [31:0] s_addr_reg, s_wdata_reg;
  logic [3:0]  s_be_reg;

  assign m0_gnt     = m0_gnt_reg;
  assign m0_rvalid  = m0_rvalid_reg;
  assign m0_err     = m0_err_reg;
  assign m0_rdata_o = m0_rdata_reg;
  assign m1_gnt     = m1_gnt_reg;
  assign m1_rvalid  = m1_rvalid_reg;
  assign m1_err     = m1_err_reg;
  assign m1_rdata_o = m1_rdata_reg;
  assign s_req_o    = s_req_reg;
  assign s_rw_o     = s_rw_reg;
  assign s_addr_o   = s_addr_reg;
  assign s_be_o     = s_be_reg;
  assign s_wdata_o  = s_wdata_reg;

  // Only byte, aligned half and aligned word accesses are legal.
  function automatic logic mask_ok(input logic [3:0] mask, input logic [1:0] off);
    logic ok;
    case (mask)
      4'b0001: ok = 1'b1;
      4'b0011: ok = ~off[0];
      4'b1111: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Bring the addressed lane down to bit 0 and extend it to 32 bits.
  function automatic logic [31:0] fmt_rdata(input logic [31:0] d, input logic [1:0] off,
                                            input logic [3:0] mask, input logic un);
    logic [31:0] lane;
    logic [31:0] res;
    lane = d >> {off, 3'b000};
    if (mask == 4'b1111)
      res = lane;
    else if (mask == 4'b0011)
      res = un ? {16'h0000, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
    else
      res = un ? {24'h000000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
    return res;
  endfunction

  logic        m1_wins;
  logic        sel_we, sel_un, sel_bad;
  logic [3:0]  sel_mask;
  logic [31:0] sel_addr, sel_wdata;

  // Pick the arbitration winner and present its request fields.
  always_comb begin
    m1_wins = m1_req && (!m0_req || (starve_reg == 3'(STARVE_LIMIT)));
    if (m1_wins) begin
      sel_we    = 1'b0;
      sel_un    = m1_un_sign;
      sel_mask  = m1_byte_mask;
      sel_addr  = m1_addr;
      sel_wdata = 32'h0;
    end else begin
      sel_we    = m0_we;
      sel_un    = m0_un_sign;
      sel_mask  = m0_byte_mask;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
    sel_bad = !mask_ok(sel_mask, sel_addr[1:0]);
  end

  logic        fin, fin_err;
  logic [31:0] fin_data;

  // Decide whether a response goes back to the owner at the next edge.
  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = 32'h0;
    case (state_reg)
      BUSY_M0, BUSY_M1: begin
        if (s_ack) begin
          fin      = 1'b1;
          fin_data = we_reg ? 32'h0 : fmt_rdata(s_rdata, off_reg, mask_reg, un_reg);
        end else if (tmo_reg == 4'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      DONE: begin
        if (pend_err_reg) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Main controller: arbitration, slave drive, timeout and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      starve_reg    <= 3'd0;
      tmo_reg       <= 4'd0;
      owner_reg     <= 1'b0;
      we_reg        <= 1'b0;
      un_reg        <= 1'b0;
      pend_err_reg  <= 1'b0;
      mask_reg      <= 4'h0;
      off_reg       <= 2'b00;
      m0_gnt_reg    <= 1'b0;
      m0_rvalid_reg <= 1'b0;
      m0_err_reg    <= 1'b0;
      m1_gnt_reg    <= 1'b0;
      m1_rvalid_reg <= 1'b0;
      m1_err_reg    <= 1'b0;
      m0_rdata_reg  <= 32'h0;
      m1_rdata_reg  <= 32'h0;
      s_req_reg     <= 1'b0;
      s_rw_reg      <= 1'b0;
      s_addr_reg    <= 32'h0;
      s_be_reg      <= 4'h0;
      s_wdata_reg   <= 32'h0;
    end else begin
      m0_gnt_reg    <= 1'b0;
      m1_gnt_reg    <= 1'b0;
      m0_rvalid_reg <= 1'b0;
      m1_rvalid_reg <= 1'b0;
      m0_err_reg    <= 1'b0;
      m1_err_reg    <= 1'b0;

      if (fin) begin
        if (owner_reg) begin
          m1_rvalid_reg <= 1'b1;
          m1_err_reg    <= fin_err;
          m1_rdata_reg  <= fin_data;
        end else begin
          m0_rvalid_reg <= 1'b1;
          m0_err_reg    <= fin_err;
          m0_rdata_reg  <= fin_data;
        end
      end

      case (state_reg)
        IDLE: begin
          // Losing with m1 waiting counts toward starvation; anything else clears it.
          if (m1_req && !m1_wins)
            starve_reg <= (starve_reg == 3'd7) ? starve_reg : starve_reg + 3'd1;
          else
            starve_reg <= 3'd0;
          if (m0_req || m1_req) begin
            owner_reg  <= m1_wins;
            we_reg     <= sel_we;
            un_reg     <= sel_un;
            mask_reg   <= sel_mask;
            off_reg    <= sel_addr[1:0];
            m0_gnt_reg <= !m1_wins;
            m1_gnt_reg <= m1_wins;
            tmo_reg    <= 4'd0;
            if (sel_bad) begin
              pend_err_reg <= 1'b1;
              state_reg    <= DONE;
            end else begin
              s_req_reg   <= 1'b1;
              s_rw_reg    <= sel_we;
              s_addr_reg  <= {sel_addr[31:2], 2'b00};
              s_be_reg    <= sel_mask << sel_addr[1:0];
              s_wdata_reg <= sel_wdata << {sel_addr[1:0], 3'b000};
              state_reg   <= m1_wins ? BUSY_M1 : BUSY_M0;
            end
          end
        end
        BUSY_M0, BUSY_M1: begin
          if (fin) begin
            s_req_reg <= 1'b0;
            state_reg <= DONE;
          end else begin
            tmo_reg <= tmo_reg + 4'd1;
          end
        end
        DONE: begin
          // A rejected request spends one extra DONE cycle so its response
          // lands two cycles after arbitration.
          if (pend_err_reg)
            pend_err_reg <= 1'b0;
          else
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: directed table, hand-written corner sequences and random
// single-master transactions checked against a byte-level reference model.
module tb_bus_arb;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_un_sign;
  logic [3:0]  m0_byte_mask;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata_o;
  logic        m1_req, m1_un_sign;
  logic [3:0]  m1_byte_mask;
  logic [31:0] m1_addr;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata_o;
  logic [31:0] s_rdata;
  logic        s_ack;
  logic        s_req_o, s_rw_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_be_o;

  int errors = 0;
  int checks = 0;

  bus_arb #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_un_sign(m0_un_sign),
    .m0_byte_mask(m0_byte_mask), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata_o(m0_rdata_o),
    .m1_req(m1_req), .m1_un_sign(m1_un_sign), .m1_byte_mask(m1_byte_mask),
    .m1_addr(m1_addr),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata_o(m1_rdata_o),
    .s_rdata(s_rdata), .s_ack(s_ack), .s_req_o(s_req_o), .s_rw_o(s_rw_o),
    .s_addr_o(s_addr_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m1;
    bit          we;
    bit          un;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] srdata;
    int          dly;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Reference model: works in whole bytes and integer arithmetic.
  function automatic vec_t make_vec(input bit m1, input bit we, input bit un,
                                    input logic [3:0] mask, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] srdata,
                                    input int dly);
    vec_t v;
    int nb, off;
    longint span, lane;
    v.m1 = m1; v.we = m1 ? 1'b0 : we; v.un = un; v.mask = mask; v.addr = addr;
    v.wdata = m1 ? 32'h0 : wdata; v.srdata = srdata; v.dly = dly;
    case (mask)
      4'h1:    nb = 1;
      4'h3:    nb = 2;
      4'hF:    nb = 4;
      default: nb = 0;
    endcase
    off = int'(addr % 4);
    if (nb == 0) v.exp_err = 1'b1;
    else         v.exp_err = ((off % nb) != 0);
    v.exp_be = 4'(((1 << nb) - 1) << off);
    v.exp_wd = 32'(longint'(v.wdata) * (longint'(1) << (8 * off)));
    span = longint'(1) << (8 * nb);
    lane = (longint'(srdata) >> (8 * off)) % span;
    if (!un && lane >= span / 2) lane = lane - span;
    v.exp_rd = (v.exp_err || v.we) ? 32'h0 : 32'(lane);
    return v;
  endfunction

  // One complete transaction from a single master, checked cycle by cycle.
  task automatic run_txn(input vec_t v, input string tag);
    logic [31:0] rd, exp_addr;
    exp_addr = v.addr & 32'hFFFF_FFFC;
    if (v.m1) begin
      m1_req = 1'b1; m1_un_sign = v.un; m1_byte_mask = v.mask; m1_addr = v.addr;
    end else begin
      m0_req = 1'b1; m0_we = v.we; m0_un_sign = v.un; m0_byte_mask = v.mask;
      m0_addr = v.addr; m0_wdata = v.wdata;
    end
    s_rdata = v.srdata;
    tick();
    chk({tag, " gnt"}, {31'h0, v.m1 ? m1_gnt : m0_gnt}, 32'h1);
    chk({tag, " other_gnt"}, {31'h0, v.m1 ? m0_gnt : m1_gnt}, 32'h0);
    // Fields may change once granted; the DUT must have latched them.
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = $urandom; m0_wdata = $urandom; m0_byte_mask = 4'($urandom);
    m0_we = 1'($urandom); m0_un_sign = 1'($urandom);
    m1_addr = $urandom; m1_byte_mask = 4'($urandom); m1_un_sign = 1'($urandom);
    if (v.exp_err) begin
      chk({tag, " s_req_err"}, {31'h0, s_req_o}, 32'h0);
      tick();
      chk({tag, " s_req_err2"}, {31'h0, s_req_o}, 32'h0);
    end else begin
      chk({tag, " s_req"}, {31'h0, s_req_o}, 32'h1);
      chk({tag, " s_rw"}, {31'h0, s_rw_o}, {31'h0, v.we});
      chk({tag, " s_addr"}, s_addr_o, exp_addr);
      chk({tag, " s_be"}, {28'h0, s_be_o}, {28'h0, v.exp_be});
      chk({tag, " s_wdata"}, s_wdata_o, v.exp_wd);
      for (int i = 0; i < v.dly; i++) begin
        tick();
        chk({tag, " hold_req"}, {31'h0, s_req_o}, 32'h1);
        chk({tag, " hold_be"}, {28'h0, s_be_o}, {28'h0, v.exp_be});
      end
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      chk({tag, " s_req_done"}, {31'h0, s_req_o}, 32'h0);
    end
    rd = v.m1 ? m1_rdata_o : m0_rdata_o;
    chk({tag, " rvalid"}, {31'h0, v.m1 ? m1_rvalid : m0_rvalid}, 32'h1);
    chk({tag, " err"}, {31'h0, v.m1 ? m1_err : m0_err}, {31'h0, v.exp_err});
    chk({tag, " rdata"}, rd, v.exp_rd);
    $display("txn %s m%0d we=%0d mask=%h addr=%h rdata=%h err=%0d",
             tag, v.m1, v.we, v.mask, v.addr, rd, v.m1 ? m1_err : m0_err);
    tick();
    chk({tag, " rvalid_pulse"}, {31'h0, v.m1 ? m1_rvalid : m0_rvalid}, 32'h0);
    chk({tag, " rdata_hold"}, v.m1 ? m1_rdata_o : m0_rdata_o, v.exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   losses;
    bit   exp1;
    vec_t v;
    logic [3:0]  mk;
    logic [31:0] ad;
    int   r;

    // {m1, we, un, mask, addr, wdata, s_rdata, ack delay, be, s_wdata, rdata, err}
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h1, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 4'b0100, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 4'h3, 32'h0000_0202, 32'h0000_BEEF, 32'h1234_5678, 1, 4'b1100, 32'hBEEF_0000, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0001, 32'h0, 32'h1111_1111, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 4'h3, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 4'b1100, 32'h0, 32'h0000_8001, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 4'h3, 32'h0000_0000, 32'h0, 32'h1234_F00D, 1, 4'b0011, 32'h0, 32'hFFFF_F00D, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 4'h1, 32'h0000_0003, 32'h0000_00AB, 32'h0, 0, 4'b1000, 32'hAB00_0000, 32'h0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 4'h5, 32'h0000_0000, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 4'h3, 32'h0000_0003, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 4'h1, 32'h0000_0001, 32'h0, 32'h0000_FF00, 3, 4'b0010, 32'h0, 32'h0000_00FF, 1'b0};

    m0_req = 0; m0_we = 0; m0_un_sign = 0; m0_byte_mask = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_un_sign = 0; m1_byte_mask = 0; m1_addr = 0;
    s_rdata = 0; s_ack = 0; rst = 1'b1;
    tick();
    s_ack = 1'b1;   // must be overridden by reset
    tick();
    s_ack = 1'b0;
    chk("reset gnt", {30'h0, m0_gnt, m1_gnt}, 32'h0);
    chk("reset rvalid_err", {28'h0, m0_rvalid, m1_rvalid, m0_err, m1_err}, 32'h0);
    chk("reset s_req_rw_be", {26'h0, s_req_o, s_rw_o, s_be_o}, 32'h0);
    chk("reset s_addr", s_addr_o, 32'h0);
    chk("reset s_wdata", s_wdata_o, 32'h0);
    chk("reset m0_rdata", m0_rdata_o, 32'h0);
    chk("reset m1_rdata", m1_rdata_o, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle no gnt", {30'h0, m0_gnt, m1_gnt}, 32'h0);

    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Simultaneous requests: m0 first, m1 on the next arbitration.
    do_reset();
    m0_we = 0; m0_byte_mask = 4'hF; m0_addr = 32'h10; m1_byte_mask = 4'hF; m1_addr = 32'h20;
    s_rdata = 32'h5555_AAAA;
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk("simul m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("simul m1_gnt_first", {31'h0, m1_gnt}, 32'h0);
    m0_req = 1'b0; s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    chk("simul m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    tick();
    chk("simul m1_no_early_gnt", {31'h0, m1_gnt}, 32'h0);
    tick();
    chk("simul m1_gnt", {31'h0, m1_gnt}, 32'h1);
    chk("simul m1_addr", s_addr_o, 32'h20);
    m1_req = 1'b0; s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    chk("simul m1_rdata", m1_rdata_o, 32'h5555_AAAA);
    $display("txn simul m0 then m1 m1_rdata=%h", m1_rdata_o);
    tick();

    // Starvation: both masters request continuously.
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; losses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp1 = (losses == STARVE_LIMIT);
      chk($sformatf("starve%0d m1_gnt", k), {31'h0, m1_gnt}, {31'h0, exp1});
      chk($sformatf("starve%0d m0_gnt", k), {31'h0, m0_gnt}, {31'h0, !exp1});
      $display("txn starve arb=%0d winner=m%0d", k + 1, m1_gnt ? 1 : 0);
      losses = exp1 ? 0 : losses + 1;
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // Timeout: slave never acks; a late ack in DONE/IDLE is ignored.
    run_txn(tbl[3], "pre_tmo");
    m0_req = 1'b1; m0_we = 1'b0; m0_byte_mask = 4'hF; m0_addr = 32'h40;
    tick();
    chk("tmo gnt", {31'h0, m0_gnt}, 32'h1);
    m0_req = 1'b0;
    chk("tmo s_req c1", {31'h0, s_req_o}, 32'h1);
    for (int i = 2; i <= TIMEOUT; i++) begin
      tick();
      chk($sformatf("tmo s_req c%0d", i), {31'h0, s_req_o}, 32'h1);
    end
    tick();
    chk("tmo rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("tmo err", {31'h0, m0_err}, 32'h1);
    chk("tmo rdata", m0_rdata_o, 32'h0);
    chk("tmo s_req_off", {31'h0, s_req_o}, 32'h0);
    $display("txn timeout m0 err=%0d rdata=%h", m0_err, m0_rdata_o);
    s_ack = 1'b1;
    tick();
    chk("tmo rvalid_pulse", {31'h0, m0_rvalid}, 32'h0);
    tick();
    s_ack = 1'b0;
    chk("stray ack", {29'h0, m0_rvalid, m1_rvalid, s_req_o}, 32'h0);

    // Reset during BUSY, with ack in the same cycle.
    run_txn(tbl[0], "pre_rst");
    m1_req = 1'b1; m1_byte_mask = 4'hF; m1_addr = 32'h80; s_rdata = 32'hCAFE_F00D;
    tick();
    chk("rstbusy gnt", {31'h0, m1_gnt}, 32'h1);
    m1_req = 1'b0; rst = 1'b1; s_ack = 1'b1;
    tick();
    rst = 1'b0; s_ack = 1'b0;
    chk("rstbusy flags", {25'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, s_req_o}, 32'h0);
    chk("rstbusy s_be_rw", {27'h0, s_rw_o, s_be_o}, 32'h0);
    chk("rstbusy s_addr", s_addr_o, 32'h0);
    chk("rstbusy m1_rdata", m1_rdata_o, 32'h0);
    $display("txn reset during BUSY");
    tick();
    chk("rstbusy no_rvalid", {30'h0, m1_rvalid, s_req_o}, 32'h0);
    run_txn(tbl[0], "post_rst");

    // Random single-master transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 7));
      case (r)
        0, 1:    mk = 4'h1;
        2, 3:    mk = 4'h3;
        4, 5:    mk = 4'hF;
        default: mk = 4'($urandom);
      endcase
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (mk == 4'h3) ad[0] = 1'b0;
        if (mk == 4'hF) ad[1:0] = 2'b00;
      end
      v = make_vec(1'($urandom), 1'($urandom), 1'($urandom), mk, ad, $urandom, $urandom,
                   int'($urandom_range(0, 3)));
      run_txn(v, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
